// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle between the UART register decode (master) and uart_tx_fifo (slave).
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8-bit UART transmitter: circular FIFO drained by a bit shifter onto tx.
// Define UART_TX_PARITY_EN for 8E1 frames (adds PARITY state); default build is 8N1.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 104,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus,
  output logic           busy,
  output logic           tx
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [15:0]         BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic                  full_c;
  logic                  empty_c;
  logic                  push;
  logic                  pop;
  logic                  baud_wrap;
  logic [7:0]            head;

  state_t                state;
  logic [15:0]           baud;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  assign full_c       = (count_q == CNT_FULL);
  assign empty_c      = (count_q == '0);
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

  assign head      = mem[rd_ptr];
  assign baud_wrap = (baud == BAUD_LAST);
  // Pops happen from IDLE or on the final stop cycle, so back-to-back frames have no gap.
  assign pop       = !empty_c && ((state == IDLE) || ((state == STOP) && baud_wrap));
  assign push      = bus.wr_en && !full_c;

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.wr_en && full_c) overflow_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
            baud  <= '0;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (baud_wrap) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end

        DATA: begin
          if (baud_wrap) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_q;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_wrap) begin
            baud  <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            baud <= baud + 16'd1;
          end
        end
`endif

        STOP: begin
          if (baud_wrap) begin
            baud <= '0;
            if (pop) begin
              shift <= head;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^head;
`endif
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLK_DIV=4, depth 4); honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

  localparam int CLK_DIV    = 4;
  localparam int DEPTH_LOG2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic tx;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, vectors=%0d miscompares=%0d", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks tx/busy for frame cycles [first,last) of byte d with hand-given even parity p.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic p,
                              input int first, input int last);
    logic [10:0] pat;
`ifdef UART_TX_PARITY_EN
    pat = {1'b1, p, d, 1'b0};
`else
    pat = {p, 1'b1, d, 1'b0};
`endif
    for (int i = first; i < last; i++) begin
      check({tag, "_tx"}, 32'(tx), 32'(pat[i / CLK_DIV]));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    tick();
    tick();
    check("rst_tx",       32'(tx),           32'd1);
    check("rst_full",     32'(bus.full),     32'd0);
    check("rst_empty",    32'(bus.empty),    32'd1);
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Single byte
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    check("e0_count", 32'(bus.count), 32'd1);
    check("e0_empty", 32'(bus.empty), 32'd0);
    check("e0_tx",    32'(tx),        32'd1);
    check("e0_busy",  32'(busy),      32'd0);
    tick();
    check("e1_tx",    32'(tx),        32'd0);
    check("e1_busy",  32'(busy),      32'd1);
    check("e1_count", 32'(bus.count), 32'd0);
    expect_frame("a5", 8'hA5, 1'b0, 0, FRAME);
    check("a5_end_busy",  32'(busy),      32'd0);
    check("a5_end_tx",    32'(tx),        32'd1);
    check("a5_end_empty", 32'(bus.empty), 32'd1);

    // Burst of five, then a sixth write while full
    bus.wr_en = 1'b1; bus.wr_data = 8'h01;
    tick();
    check("b1_count", 32'(bus.count), 32'd1);
    check("b1_busy",  32'(busy),      32'd0);
    bus.wr_data = 8'h02;
    tick();
    check("b2_count", 32'(bus.count), 32'd1);
    check("b2_tx",    32'(tx),        32'd0);
    check("b2_busy",  32'(busy),      32'd1);
    bus.wr_data = 8'h03;
    tick();
    check("b3_count", 32'(bus.count), 32'd2);
    bus.wr_data = 8'h04;
    tick();
    check("b4_count", 32'(bus.count), 32'd3);
    bus.wr_data = 8'h05;
    tick();
    check("b5_count",    32'(bus.count),    32'd4);
    check("b5_full",     32'(bus.full),     32'd1);
    check("b5_overflow", 32'(bus.overflow), 32'd0);
    check("b5_tx",       32'(tx),           32'd0);
    bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    check("ovf_flag",  32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count),    32'd4);
    check("ovf_full",  32'(bus.full),     32'd1);
    expect_frame("f01", 8'h01, 1'b1, 4, FRAME);
    check("f01_count", 32'(bus.count), 32'd3);
    expect_frame("f02", 8'h02, 1'b1, 0, FRAME);
    check("f02_count", 32'(bus.count), 32'd2);
    expect_frame("f03", 8'h03, 1'b0, 0, FRAME);
    check("f03_count", 32'(bus.count), 32'd1);
    expect_frame("f04", 8'h04, 1'b1, 0, FRAME);
    check("f04_count", 32'(bus.count), 32'd0);
    check("f04_empty", 32'(bus.empty), 32'd1);
    expect_frame("f05", 8'h05, 1'b0, 0, FRAME);
    check("burst_end_busy", 32'(busy),         32'd0);
    check("burst_end_tx",   32'(tx),           32'd1);
    check("ovf_sticky",     32'(bus.overflow), 32'd1);

    // Write coinciding with the pop on the last stop cycle
    bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
    tick();
    bus.wr_data = 8'h5A;
    tick();
    bus.wr_en = 1'b0;
    check("sw_count0", 32'(bus.count), 32'd1);
    expect_frame("f3c", 8'h3C, 1'b0, 0, FRAME - 1);
    check("sw_last_tx",    32'(tx),        32'd1);
    check("sw_last_count", 32'(bus.count), 32'd1);
    bus.wr_en = 1'b1; bus.wr_data = 8'h81;
    tick();
    bus.wr_en = 1'b0;
    check("sw_count1", 32'(bus.count), 32'd1);
    expect_frame("f5a", 8'h5A, 1'b0, 0, FRAME);
    check("sw_count2", 32'(bus.count), 32'd0);
    expect_frame("f81", 8'h81, 1'b0, 0, FRAME);
    check("sw_end_busy", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    bus.wr_en = 1'b1; bus.wr_data = 8'h07;
    tick();
    bus.wr_en = 1'b0;
    tick();
    expect_frame("f07", 8'h07, 1'b1, 0, FRAME);
    check("par_end_busy", 32'(busy), 32'd0);
`endif

    // Reset during data bit 3 with two bytes queued
    bus.wr_en = 1'b1; bus.wr_data = 8'h11;
    tick();
    bus.wr_data = 8'h22;
    tick();
    bus.wr_data = 8'h33;
    tick();
    bus.wr_en = 1'b0;
    check("mr_count", 32'(bus.count), 32'd2);
    expect_frame("f11", 8'h11, 1'b0, 1, 17);
    reset = 1'b1;
    tick();
    check("mr_tx",       32'(tx),           32'd1);
    check("mr_count0",   32'(bus.count),    32'd0);
    check("mr_busy",     32'(busy),         32'd0);
    check("mr_overflow", 32'(bus.overflow), 32'd0);
    check("mr_empty",    32'(bus.empty),    32'd1);
    reset = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      check("mr_idle_tx",   32'(tx),   32'd1);
      check("mr_idle_busy", 32'(busy), 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
